cw305_axi_sram: RTL and testbench
=================================

CW305_AXI_SRAM -- requirements
Module: cw305_axi_sram

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, giving log2 of the memory depth in 32-bit words (256 words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port s_awvalid, input, 1 bit: write address valid.
REQ-006 SHALL have port s_awready, output, 1 bit: write address ready.
REQ-007 SHALL have port s_awaddr, input, 32 bits: write byte address.
REQ-008 SHALL have port s_wvalid, input, 1 bit: write data valid.
REQ-009 SHALL have port s_wready, output, 1 bit: write data ready.
REQ-010 SHALL have port s_wdata, input, 32 bits: write data.
REQ-011 SHALL have port s_wstrb, input, 4 bits: byte enables, where bit i enables wdata[8i+7:8i].
REQ-012 SHALL have port s_bvalid, output, 1 bit: write response valid.
REQ-013 SHALL have port s_bready, input, 1 bit: write response ready.
REQ-014 SHALL have port s_bresp, output, 2 bits: write response, OKAY=2'b00 or SLVERR=2'b10.
REQ-015 SHALL have port s_arvalid, input, 1 bit: read address valid.
REQ-016 SHALL have port s_arready, output, 1 bit: read address ready.
REQ-017 SHALL have port s_araddr, input, 32 bits: read byte address.
REQ-018 SHALL have port s_rvalid, output, 1 bit: read data valid.
REQ-019 SHALL have port s_rready, input, 1 bit: read data ready.
REQ-020 SHALL have ports s_rdata (output, 32 bits, read data) and s_rresp (output, 2 bits, read response).

Function
REQ-021 SHALL implement an AXI4-Lite slave RAM, serving as the memory-side stage behind the cw305_axi master.
REQ-022 SHALL run the write path as an FSM with states W_IDLE, W_GOT_AW, W_GOT_W, and W_RESP.
- W_IDLE: an AW handshake moves to W_GOT_AW, a W handshake moves to W_GOT_W, and both in the same cycle move straight to W_RESP.
- W_GOT_AW / W_GOT_W: the missing half's handshake moves to W_RESP.
REQ-023 SHALL drive s_awready high only in W_IDLE and W_GOT_W, and s_wready high only in W_IDLE and W_GOT_AW; each captured address or data word is held in a register.
REQ-024 SHALL commit the memory write in the cycle of entry to W_RESP, writing only the bytes whose s_wstrb bit is set, and SHALL assert s_bvalid from the next cycle.
REQ-025 SHALL hold s_bvalid and s_bresp stable until s_bready is high, then return to W_IDLE; no new AW or W is accepted in W_RESP.
REQ-026 SHALL run the read path as an FSM with states R_IDLE and R_DATA; s_arready is high only in R_IDLE, and an AR handshake registers the read and moves to R_DATA.
REQ-027 SHALL make s_rvalid rise exactly 1 cycle after the AR handshake, and SHALL hold s_rdata and s_rresp stable until s_rready is high, then return to R_IDLE.
REQ-028 SHALL compute the word index as (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
REQ-029 SHALL treat an address outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2) as out of range: the response is SLVERR, the memory is left unmodified, and s_rdata is 32'h0.
REQ-030 SHALL keep the read and write paths independent; when both hit the same word in the same cycle, the read returns the pre-write data (read-first).
REQ-031 SHALL treat s_wstrb = 4'b0000 as a legal write that modifies nothing and responds OKAY.

Reset
REQ-032 SHALL, while resetn is low, force both FSMs to their IDLE states and drive s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=2'b00, s_rresp=2'b00, s_rdata=32'h0.
REQ-033 SHALL leave memory contents unchanged by reset; a transaction cut off by reset is discarded with no response.

Structure
REQ-034 SHALL place the response codes (RESP_OKAY, RESP_SLVERR) and the FSM state encodings in the shared package cw305_axi_pkg.
REQ-035 SHALL isolate the storage array (one write port with byte enables, one synchronous read port) in the sub-module cw305_axi_sram_array.

Verification
REQ-036 SHALL verify: AW and W in the same cycle to 0x10 with data 32'hDEADBEEF and strobe 4'hF -> s_bvalid 1 cycle later with OKAY; a subsequent read of 0x10 returns DEADBEEF with s_rvalid 1 cycle after AR.
REQ-037 SHALL verify: W sent 3 cycles before AW, with strobe 4'b0101 and data 32'h11223344 over 32'hFFFFFFFF -> a read returns 32'hFF22FF44.
REQ-038 SHALL verify: a write to 0x400 with DEPTH_LOG2=8 -> SLVERR; a read of 0x400 -> SLVERR with rdata 0; word 0 is unchanged.
REQ-039 SHALL verify: s_bready and s_rready held low for 5 cycles -> valid and response held stable; arready, awready, and wready stay low until ready.
REQ-040 SHALL verify: a same-cycle read and write to 0x20 holding 32'hA5A5A5A5, writing 32'h0 -> the read returns A5A5A5A5 and the next read returns 0.
REQ-041 SHALL verify: resetn dropped while in W_GOT_AW -> all outputs at reset values, and no B response after resetn is released.

Source files
------------

// File: rtl/cw305_axi_pkg.sv
// Shared definitions for the CW305 AXI4-Lite blocks: response codes, FSM
// state encodings and the address range check.
package cw305_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // off is (addr - base); a base-relative wrap makes addresses below base huge.
  function automatic logic offset_in_range(input logic [31:0] off, input int unsigned span_log2);
    return (off >> span_log2) == 32'd0;
  endfunction

endpackage

// File: rtl/cw305_axi_sram_array.sv
// Word storage: one byte-enabled write port and one registered read port.
// A read and a write to the same word in one cycle returns the old data.
module cw305_axi_sram_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rdata_q;

      always_ff @(posedge clk) begin
        if (we && wstrb[gi]) mem[waddr] <= wdata[8*gi +: 8];
        if (re) rdata_q <= mem[raddr];
      end

      assign rdata[8*gi +: 8] = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/cw305_axi_sram.sv
// AXI4-Lite slave RAM behind the CW305 AXI master. Independent write and
// read FSMs share a byte-enabled array; out-of-range accesses get SLVERR.
module cw305_axi_sram
  import cw305_axi_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp
);

  w_state_e    w_state_q, w_state_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rd_oor_q, rd_oor_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        aw_hs, w_hs, ar_hs, commit, mem_we, wr_ok, rd_ok;
  logic [31:0] wr_off, rd_off, wr_data, arr_rdata;
  logic [3:0]  wr_strb;

  assign aw_hs = s_awvalid && awready_q;
  assign w_hs  = s_wvalid && wready_q;
  assign ar_hs = s_arvalid && arready_q;

  // Whichever half arrived earlier comes from its holding register.
  assign wr_off  = ((w_state_q == W_GOT_AW) ? awaddr_q : s_awaddr) - BASE_ADDR;
  assign wr_data = (w_state_q == W_GOT_W) ? wdata_q : s_wdata;
  assign wr_strb = (w_state_q == W_GOT_W) ? wstrb_q : s_wstrb;
  assign wr_ok   = offset_in_range(wr_off, DEPTH_LOG2 + 2);
  assign rd_off  = s_araddr - BASE_ADDR;
  assign rd_ok   = offset_in_range(rd_off, DEPTH_LOG2 + 2);

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d = W_RESP;
          commit    = 1'b1;
        end else if (aw_hs) begin
          w_state_d = W_GOT_AW;
          awaddr_d  = s_awaddr;
        end else if (w_hs) begin
          w_state_d = W_GOT_W;
          wdata_d   = s_wdata;
          wstrb_d   = s_wstrb;
        end
      end
      W_GOT_AW: if (w_hs) begin
        w_state_d = W_RESP;
        commit    = 1'b1;
      end
      W_GOT_W: if (aw_hs) begin
        w_state_d = W_RESP;
        commit    = 1'b1;
      end
      default: if (s_bready) w_state_d = W_IDLE;
    endcase
    if (commit) bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
    mem_we    = commit && wr_ok;
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_GOT_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_GOT_AW);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    rd_oor_d  = rd_oor_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_DATA;
        rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
        rd_oor_d  = !rd_ok;
      end
      default: if (s_rready) r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rd_oor_q  <= rd_oor_d;
      rresp_q   <= rresp_d;
    end
  end

  cw305_axi_sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_off[DEPTH_LOG2+1:2]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (ar_hs && rd_ok),
    .raddr (rd_off[DEPTH_LOG2+1:2]),
    .rdata (arr_rdata)
  );

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = (rvalid_q && !rd_oor_q) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_cw305_axi_sram.sv
// Directed bench for cw305_axi_sram: fixed-latency handshakes, byte strobes,
// range errors, backpressure, read-first collision and mid-transaction reset.
module tb_cw305_axi_sram;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_awvalid = 1'b0, s_awready;
  logic [31:0] s_awaddr = 32'h0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [31:0] s_wdata = 32'h0;
  logic [3:0]  s_wstrb = 4'h0;
  logic        s_bvalid, s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic        s_arvalid = 1'b0, s_arready;
  logic [31:0] s_araddr = 32'h0;
  logic        s_rvalid, s_rready = 1'b0;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cw305_axi_sram dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " awready"}, 32'(s_awready), 32'd1);
    check({tag, " wready"},  32'(s_wready),  32'd1);
    check({tag, " arready"}, 32'(s_arready), 32'd1);
    check({tag, " bvalid"},  32'(s_bvalid),  32'd0);
    check({tag, " rvalid"},  32'(s_rvalid),  32'd0);
    check({tag, " bresp"},   32'(s_bresp),   32'd0);
    check({tag, " rresp"},   32'(s_rresp),   32'd0);
    check({tag, " rdata"},   s_rdata,        32'd0);
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    s_awvalid = 1'b1; s_awaddr = addr;
    s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb;
    s_bready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check({tag, " bvalid"}, 32'(s_bvalid), 32'd1);
    check({tag, " bresp"}, 32'(s_bresp), 32'(exp_resp));
    tick();
    check({tag, " bvalid drop"}, 32'(s_bvalid), 32'd0);
    s_bready = 1'b0;
    $display("write %s addr=%h data=%h strb=%b bresp=%0d", tag, addr, data, strb, exp_resp);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    s_arvalid = 1'b1; s_araddr = addr; s_rready = 1'b1;
    tick();
    s_arvalid = 1'b0;
    check({tag, " rvalid"}, 32'(s_rvalid), 32'd1);
    check({tag, " rdata"}, s_rdata, exp_data);
    check({tag, " rresp"}, 32'(s_rresp), 32'(exp_resp));
    tick();
    check({tag, " rvalid drop"}, 32'(s_rvalid), 32'd0);
    s_rready = 1'b0;
    $display("read  %s addr=%h expect=%h rresp=%0d", tag, addr, exp_data, exp_resp);
  endtask

  initial begin
    tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    // Same-cycle AW+W, then read back.
    axi_write("t1 wr", 32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    axi_read("t1 rd", 32'h10, 32'hDEADBEEF, 2'b00);

    // Zero strobe: OKAY, nothing modified.
    axi_write("strb0 wr", 32'h10, 32'h0, 4'h0, 2'b00);
    axi_read("strb0 rd", 32'h10, 32'hDEADBEEF, 2'b00);

    // W leads AW by 3 cycles with partial strobe.
    axi_write("t2 pre", 32'h14, 32'hFFFFFFFF, 4'hF, 2'b00);
    s_wvalid = 1'b1; s_wdata = 32'h11223344; s_wstrb = 4'b0101;
    tick();
    s_wvalid = 1'b0;
    check("t2 got_w awready", 32'(s_awready), 32'd1);
    check("t2 got_w wready", 32'(s_wready), 32'd0);
    tick();
    tick();
    check("t2 no early bvalid", 32'(s_bvalid), 32'd0);
    s_awvalid = 1'b1; s_awaddr = 32'h14; s_bready = 1'b1;
    tick();
    s_awvalid = 1'b0;
    check("t2 bvalid", 32'(s_bvalid), 32'd1);
    check("t2 bresp", 32'(s_bresp), 32'd0);
    tick();
    s_bready = 1'b0;
    $display("write t2 split addr=00000014 data=11223344 strb=0101");
    axi_read("t2 rd", 32'h14, 32'hFF22FF44, 2'b00);

    // Out of range.
    axi_write("t3 w0", 32'h0, 32'h12345678, 4'hF, 2'b00);
    axi_write("t3 oor wr", 32'h400, 32'hBAD0BAD0, 4'hF, 2'b10);
    axi_read("t3 oor rd", 32'h400, 32'h0, 2'b10);
    axi_read("t3 w0 rd", 32'h0, 32'h12345678, 2'b00);

    // Backpressure on B (SLVERR so a nonzero response must stay put) and on R.
    s_awvalid = 1'b1; s_awaddr = 32'h404; s_wvalid = 1'b1; s_wdata = 32'h1; s_wstrb = 4'hF;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4 b hold bvalid", 32'(s_bvalid), 32'd1);
      check("t4 b hold bresp", 32'(s_bresp), 32'd2);
      check("t4 b hold awready", 32'(s_awready), 32'd0);
      check("t4 b hold wready", 32'(s_wready), 32'd0);
      tick();
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check("t4 b release awready", 32'(s_awready), 32'd1);
    check("t4 b release wready", 32'(s_wready), 32'd1);
    $display("write t4 stalled addr=00000404 bresp=2");
    s_arvalid = 1'b1; s_araddr = 32'h10;
    tick();
    s_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4 r hold rvalid", 32'(s_rvalid), 32'd1);
      check("t4 r hold rdata", s_rdata, 32'hDEADBEEF);
      check("t4 r hold rresp", 32'(s_rresp), 32'd0);
      check("t4 r hold arready", 32'(s_arready), 32'd0);
      tick();
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check("t4 r release arready", 32'(s_arready), 32'd1);
    check("t4 r release rvalid", 32'(s_rvalid), 32'd0);
    $display("read  t4 stalled addr=00000010 expect=deadbeef");

    // Same-cycle read and write of one word: read-first.
    axi_write("t5 pre", 32'h20, 32'hA5A5A5A5, 4'hF, 2'b00);
    s_awvalid = 1'b1; s_awaddr = 32'h20; s_wvalid = 1'b1; s_wdata = 32'h0; s_wstrb = 4'hF;
    s_arvalid = 1'b1; s_araddr = 32'h20; s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check("t5 coll bvalid", 32'(s_bvalid), 32'd1);
    check("t5 coll rvalid", 32'(s_rvalid), 32'd1);
    check("t5 coll rdata", s_rdata, 32'hA5A5A5A5);
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    $display("coll  t5 addr=00000020 read-first");
    axi_read("t5 after", 32'h20, 32'h0, 2'b00);

    // Reset while holding an address in W_GOT_AW.
    s_awvalid = 1'b1; s_awaddr = 32'h30;
    tick();
    s_awvalid = 1'b0;
    check("t6 got_aw awready", 32'(s_awready), 32'd0);
    check("t6 got_aw wready", 32'(s_wready), 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("t6 in reset");
    tick();
    resetn = 1'b1;
    s_bready = 1'b1;
    s_wvalid = 1'b1; s_wdata = 32'h77777777; s_wstrb = 4'hF;
    tick();
    s_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6 no bvalid", 32'(s_bvalid), 32'd0);
      tick();
    end
    s_bready = 1'b0;
    $display("reset t6 mid-write discarded");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
